// File: rtl/multdiv_unit.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and signed divide (restoring),
// 32 iterations each, with registered result, exception flag and one-cycle ready pulse.
module multdiv_unit (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    localparam logic [5:0] LAST_ITER = 6'd32;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] res_q, res_d;
    logic        exc_q, exc_d;
    logic        rdy_q, rdy_d;
    logic        busy_q, busy_d;

    logic signed [31:0] mcand_q;
    logic [64:0]        prod_q;
    logic [31:0]        rem_q, quo_q, dvs_q;
    logic               neg_q, dz_q, ovf_q;

    logic start_ok, start_mul, start_div, iterate, finish;

    // One Booth step: add/subtract multiplicand into the sign-extended upper half, then shift.
    function automatic logic [64:0] booth_step(input logic [64:0] p, input logic signed [31:0] m);
        logic [32:0] hi;
        hi = {p[64], p[64:33]};
        case (p[1:0])
            2'b01:   hi = hi + {m[31], m};
            2'b10:   hi = hi - {m[31], m};
            default: hi = hi;
        endcase
        return {hi, p[32:1]};
    endfunction

    // One restoring-division step on unsigned magnitudes; returns {remainder, quotient}.
    function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] quo,
                                             input logic [31:0] dvs);
        logic [32:0] trial;
        trial = {rem, quo[31]} - {1'b0, dvs};
        if (!trial[32])
            return {trial[31:0], quo[30:0], 1'b1};
        return {rem[30:0], quo[31], quo[30:0], 1'b0};
    endfunction

    function automatic logic [31:0] abs32(input logic signed [31:0] v);
        logic [31:0] u;
        u = v;
        return v[31] ? (~u + 32'd1) : u;
    endfunction

    // Product overflows 32 bits unless bits [63:31] are a pure sign extension.
    function automatic logic mul_ovf(input logic [32:0] top);
        return !((&top) || !(|top));
    endfunction

    assign start_ok  = (state_q == IDLE) || (state_q == DONE);
    assign start_mul = start_ok && ctrl_MULT;
    assign start_div = start_ok && !ctrl_MULT && ctrl_DIV;
    assign iterate   = ((state_q == MUL) || (state_q == DIV)) && (cnt_q != LAST_ITER);
    assign finish    = ((state_q == MUL) || (state_q == DIV)) && (cnt_q == LAST_ITER);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            res_q   <= 32'd0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_mul)      state_d = MUL;
                else if (start_div) state_d = DIV;
                else                state_d = IDLE;
            end
            MUL, DIV: begin
                if (cnt_q == LAST_ITER) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (start_mul || start_div) cnt_d = 6'd0;
        else if (iterate)           cnt_d = cnt_q + 6'd1;

        res_d = res_q;
        exc_d = exc_q;
        if (finish) begin
            if (state_q == MUL) begin
                res_d = prod_q[32:1];
                exc_d = mul_ovf(prod_q[64:32]);
            end else if (dz_q) begin
                res_d = 32'd0;
                exc_d = 1'b1;
            end else if (ovf_q) begin
                res_d = 32'h8000_0000;
                exc_d = 1'b1;
            end else begin
                res_d = neg_q ? (~quo_q + 32'd1) : quo_q;
                exc_d = 1'b0;
            end
        end

        rdy_d  = (state_d == DONE);
        // Stall is released once the last iteration has been taken.
        busy_d = ((state_d == MUL) || (state_d == DIV)) && (cnt_d != LAST_ITER);
    end

    always_ff @(posedge clock) begin
        if (start_mul || start_div) begin
            mcand_q <= data_operandA;
            prod_q  <= {32'd0, data_operandB, 1'b0};
            rem_q   <= 32'd0;
            quo_q   <= abs32(data_operandA);
            dvs_q   <= abs32(data_operandB);
            neg_q   <= data_operandA[31] ^ data_operandB[31];
            dz_q    <= (data_operandB == 32'd0);
            ovf_q   <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        end else if (iterate) begin
            if (state_q == MUL) prod_q <= booth_step(prod_q, mcand_q);
            else                {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_q);
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: table of multiply/divide vectors plus
// hand-written sequences for ignored strobes, back-to-back starts and mid-op reset.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;

    multdiv_unit dut (
        .clock          (clock),
        .resetn         (resetn),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic start(input logic is_div, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT = !is_div;
        ctrl_DIV  = is_div;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_rdy(output int lat, output int bcnt);
        int guard;
        guard = 0;
        bcnt = busy ? 1 : 0;
        while (!data_resultRDY && guard < 60) begin
            @(posedge clock);
            #1;
            if (busy) bcnt++;
            guard++;
        end
        lat = data_resultRDY ? (cyc - t0) : -1;
    endtask

    initial begin
        int lat, bcnt;
        logic [31:0] held;
        logic seen;

        vecs[0]  = '{1'b0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0};
        vecs[1]  = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
        vecs[2]  = '{1'b0, 32'hFFFF_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
        vecs[3]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[5]  = '{1'b0, 32'h7FFF_FFFF, 32'd2,          32'hFFFF_FFFE, 1'b1};
        vecs[6]  = '{1'b0, 32'h0000_8000, 32'hFFFF_0000, 32'h8000_0000, 1'b0};
        vecs[7]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b0};
        vecs[8]  = '{1'b1, 32'd100,        32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0};
        vecs[9]  = '{1'b1, 32'd5,          32'd0,          32'h0000_0000, 1'b1};
        vecs[10] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[11] = '{1'b1, 32'h8000_0000, 32'd2,          32'hC000_0000, 1'b0};
        vecs[12] = '{1'b1, 32'h7FFF_FFFF, 32'd1,          32'h7FFF_FFFF, 1'b0};
        vecs[13] = '{1'b1, 32'd0,          32'd5,          32'h0000_0000, 1'b0};
        vecs[14] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0};

        repeat (3) @(posedge clock);
        #1;
        chk("reset_result", data_result, 32'd0);
        chk("reset_exc", {31'd0, data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < 15; i++) begin
            start(vecs[i].is_div, vecs[i].a, vecs[i].b);
            wait_rdy(lat, bcnt);
            chk($sformatf("v%0d_latency", i), lat, 32'd33);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, 32'd32);
            chk($sformatf("v%0d_result", i), data_result, vecs[i].res);
            chk($sformatf("v%0d_exc", i), {31'd0, data_exception}, {31'd0, vecs[i].exc});
            chk($sformatf("v%0d_busy_in_rdy", i), {31'd0, busy}, 32'd0);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_rdy_one_cycle", i), {31'd0, data_resultRDY}, 32'd0);
            chk($sformatf("v%0d_result_held", i), data_result, vecs[i].res);
        end

        // MULT 3x4 with an ignored DIV strobe mid-operation
        start(1'b0, 32'd3, 32'd4);
        repeat (4) @(posedge clock);
        @(negedge clock);
        ctrl_DIV = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        chk("strobe_busy", {31'd0, busy}, 32'd1);
        wait_rdy(lat, bcnt);
        chk("strobe_latency", lat, 32'd33);
        chk("strobe_result", data_result, 32'd12);
        chk("strobe_exc", {31'd0, data_exception}, 32'd0);

        // Back-to-back DIV 12/5 issued in the RDY cycle
        start(1'b1, 32'd12, 32'd5);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_rdy_low", {31'd0, data_resultRDY}, 32'd0);
        chk("b2b_result_kept", data_result, 32'd12);
        wait_rdy(lat, bcnt);
        chk("b2b_latency", lat, 32'd33);
        chk("b2b_busy_cycles", bcnt, 32'd32);
        chk("b2b_result", data_result, 32'd2);
        chk("b2b_exc", {31'd0, data_exception}, 32'd0);

        // Reset in the middle of MULT 9x9
        start(1'b0, 32'd9, 32'd9);
        repeat (9) @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        chk("midrst_result", data_result, 32'd0);
        chk("midrst_exc", {31'd0, data_exception}, 32'd0);
        chk("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        seen = 1'b0;
        held = 32'd0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen = 1'b1;
            if (busy) held = held + 32'd1;
        end
        chk("midrst_no_rdy", {31'd0, seen}, 32'd0);
        chk("midrst_no_busy", held, 32'd0);

        start(1'b0, 32'd9, 32'd9);
        wait_rdy(lat, bcnt);
        chk("after_rst_latency", lat, 32'd33);
        chk("after_rst_result", data_result, 32'd81);
        chk("after_rst_exc", {31'd0, data_exception}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
